// File: rtl/cplx_round_clip_buffer.sv
// Complex {I,Q} round-and-saturate AXI-Stream output stage: one flop stage plus an optional FIFO.
// Defining CPLX_RC_SAT_FLAG_EN adds o_sat, a per-beat saturation flag carried with the data.

// Generic FIFO, 2**AW entries; read data comes straight from the storage registers.
// A write while full is taken only if a read leaves in the same cycle; clear_i empties it.
module cplx_rc_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          full,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat,
  output logic [AW:0]   cnt
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign full   = (cnt_q == FULL_CNT);
  assign rd_vld = (cnt_q != '0);
  assign pop    = rd_vld & rd_rdy;
  assign push   = wr_vld & (~full | pop);
  assign cnt    = cnt_q;
  // Zero while empty so a flushed FIFO shows the same outputs as after reset.
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Rounds (ties to +inf) and saturates each I/Q part, registers one beat, optionally buffers in a FIFO.
// Latency 1 cycle without FIFO, 2 with; with a FIFO, i_tready depends only on registered state.
module cplx_round_clip_buffer #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int CLIP_BITS = 1,
  parameter int FIFOSIZE  = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [2*WIDTH_IN-1:0]  i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [2*WIDTH_OUT-1:0] o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready,
`ifdef CPLX_RC_SAT_FLAG_EN
  output logic                   o_sat,
`endif
  output logic [FIFOSIZE:0]      occupied_o
);
  localparam int D  = WIDTH_IN - WIDTH_OUT - CLIP_BITS;
  localparam int RW = WIDTH_IN + 1 - D;
`ifdef CPLX_RC_SAT_FLAG_EN
  localparam int SATW = 1;
`else
  localparam int SATW = 0;
`endif
  // Entry layout: {[sat], tlast, I, Q}
  localparam int EW = 2*WIDTH_OUT + 1 + SATW;
  localparam logic signed [WIDTH_IN:0] HALF = (WIDTH_IN+1)'(1) <<< (D-1);

  function automatic logic [RW-1:0] rnd(input logic [WIDTH_IN-1:0] x);
    return RW'(($signed({x[WIDTH_IN-1], x}) + HALF) >>> D);
  endfunction

  function automatic logic is_sat(input logic [RW-1:0] r);
    return !((&r[RW-1:WIDTH_OUT-1]) || !(|r[RW-1:WIDTH_OUT-1]));
  endfunction

  function automatic logic [WIDTH_OUT-1:0] clip(input logic [RW-1:0] r);
    logic [WIDTH_OUT-1:0] v;
    if (!is_sat(r)) begin
      v = r[WIDTH_OUT-1:0];
    end else if (r[RW-1]) begin
      v = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end
    return v;
  endfunction

  logic [RW-1:0] re_rnd, im_rnd;
  logic [EW-1:0] in_ent;
  logic [EW-1:0] out_ent;
  logic          rdy_en_q, rdy_en_d;
  logic          s1_vld_q, s1_vld_d;
  logic [EW-1:0] s1_ent_q, s1_ent_d;
  logic          s1_pop;
  logic          in_fire;

  always_comb begin
    re_rnd = rnd(i_tdata[2*WIDTH_IN-1:WIDTH_IN]);
    im_rnd = rnd(i_tdata[WIDTH_IN-1:0]);
    in_ent = '0;
    in_ent[2*WIDTH_OUT:0] = {i_tlast, clip(re_rnd), clip(im_rnd)};
`ifdef CPLX_RC_SAT_FLAG_EN
    in_ent[EW-1] = is_sat(re_rnd) | is_sat(im_rnd);
`endif
  end

  // rdy_en_q keeps i_tready low during reset and lifts it on the first edge after release.
  assign i_tready = rdy_en_q & (~s1_vld_q | s1_pop);
  assign in_fire  = i_tvalid & i_tready;

  always_comb begin
    rdy_en_d = 1'b1;
    s1_vld_d = s1_vld_q;
    s1_ent_d = s1_ent_q;
    if (clear_i) begin
      s1_vld_d = 1'b0;
      s1_ent_d = '0;
    end else if (in_fire) begin
      s1_vld_d = 1'b1;
      s1_ent_d = in_ent;
    end else if (s1_pop) begin
      s1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_ent_q <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      s1_vld_q <= s1_vld_d;
      s1_ent_q <= s1_ent_d;
    end
  end

  generate
    if (FIFOSIZE == 0) begin : g_direct
      assign s1_pop     = s1_vld_q & o_tready;
      assign o_tvalid   = s1_vld_q;
      assign out_ent    = s1_ent_q;
      assign occupied_o = '0;
    end else begin : g_fifo
      logic fifo_full;
      // Stage 1 moves on only when the FIFO has room by its registered count,
      // so o_tready never reaches i_tready combinationally.
      assign s1_pop = s1_vld_q & ~fifo_full;

      cplx_rc_fifo #(
        .DW (EW),
        .AW (FIFOSIZE)
      ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .wr_vld  (s1_pop),
        .wr_dat  (s1_ent_q),
        .full    (fifo_full),
        .rd_vld  (o_tvalid),
        .rd_rdy  (o_tready),
        .rd_dat  (out_ent),
        .cnt     (occupied_o)
      );
    end
  endgenerate

  assign o_tdata = out_ent[2*WIDTH_OUT-1:0];
  assign o_tlast = out_ent[2*WIDTH_OUT];
`ifdef CPLX_RC_SAT_FLAG_EN
  assign o_sat   = out_ent[EW-1];
`endif
endmodule

// File: tb/tb_cplx_round_clip_buffer.sv
// Scoreboard bench for cplx_round_clip_buffer (FIFOSIZE=2); reference model uses plain integer arithmetic.
module tb_cplx_round_clip_buffer;
  localparam int WI = 32;
  localparam int WO = 16;
  localparam int CB = 1;
  localparam int FS = 2;
  localparam int D  = WI - WO - CB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic [2*WI-1:0] i_tdata = '0;
  logic i_tlast = 1'b0;
  logic i_tvalid = 1'b0;
  logic i_tready;
  logic [2*WO-1:0] o_tdata;
  logic o_tlast;
  logic o_tvalid;
  logic o_tready = 1'b0;
  logic [FS:0] occupied;
`ifdef CPLX_RC_SAT_FLAG_EN
  logic o_sat;
`endif

  typedef struct packed {
    logic [2*WO-1:0] dat;
    logic            last;
    logic            sat;
  } exp_t;

  exp_t exp_q[$];
  int   out_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   last_acc_cyc = 0;
  int   sat_beats = 0;
  logic hold_vld = 1'b0;
  logic [2*WO:0] hold_val = '0;

  cplx_round_clip_buffer #(
    .WIDTH_IN  (WI),
    .WIDTH_OUT (WO),
    .CLIP_BITS (CB),
    .FIFOSIZE  (FS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
`ifdef CPLX_RC_SAT_FLAG_EN
    .o_sat      (o_sat),
`endif
    .occupied_o (occupied)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Round half toward +inf then saturate, using integer floor division.
  function automatic logic [WO-1:0] ref_part(input logic [WI-1:0] x, output logic s);
    longint scale, v, q, hi, lo;
    scale = longint'(1) << D;
    hi    = (longint'(1) << (WO-1)) - 1;
    lo    = -(longint'(1) << (WO-1));
    v     = longint'($signed(x)) + scale / 2;
    q     = v / scale;
    if (v < 0 && (v % scale) != 0) q = q - 1;
    s = 1'b0;
    if (q > hi) begin
      q = hi;
      s = 1'b1;
    end else if (q < lo) begin
      q = lo;
      s = 1'b1;
    end
    return q[WO-1:0];
  endfunction

  function automatic exp_t ref_beat(input logic [2*WI-1:0] d, input logic last);
    exp_t e;
    logic si, sq;
    logic [WO-1:0] pi, pq;
    pi = ref_part(d[2*WI-1:WI], si);
    pq = ref_part(d[WI-1:0], sq);
    e.dat  = {pi, pq};
    e.last = last;
    e.sat  = si | sq;
    return e;
  endfunction

  function automatic logic [WI-1:0] rand_part();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h3FFF0000 + $urandom_range(0, 32'h1FFFF);
      2: return 32'hC0000000 - $urandom_range(0, 32'h1FFFF);
      default: return ($urandom_range(0, 15) * 32'h4000) - 32'h20000;
    endcase
  endfunction

  // One clock: drive at posedge+1, decide handshake at negedge, return at next posedge+1.
  task automatic step(input logic vld, input logic [2*WI-1:0] dat, input logic last,
                      input exp_t e, output logic acc);
    i_tvalid = vld;
    i_tdata  = dat;
    i_tlast  = last;
    case (rdy_mode)
      0: o_tready = 1'b0;
      1: o_tready = 1'b1;
      default: o_tready = ($urandom_range(0, 1) == 1);
    endcase
    @(negedge clk);
    acc = vld && i_tready && rst_n;
    if (acc) last_acc_cyc = cyc;
    if (acc && !clear) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, acc);
  endtask

  task automatic send(input logic [2*WI-1:0] dat, input logic last, input exp_t e);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(1'b1, dat, last, e, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 200 cycles", dat);
    end
  endtask

  task automatic send_rand(input logic last);
    logic [2*WI-1:0] d;
    d = {rand_part(), rand_part()};
    send(d, last, ref_beat(d, last));
  endtask

  task automatic drain();
    int n;
    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      idle(1);
      n++;
    end
    idle(3);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && o_tvalid) chk("stall_stable", 64'({o_tlast, o_tdata}), 64'(hold_val));
      if (o_tvalid && o_tready) begin
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h last=%0b, required no output", o_tdata, o_tlast);
        end else begin
          e = exp_q.pop_front();
          if (e.sat) sat_beats++;
          chk("out_tdata", 64'(o_tdata), 64'(e.dat));
          chk("out_tlast", 64'(o_tlast), 64'(e.last));
`ifdef CPLX_RC_SAT_FLAG_EN
          chk("out_sat", 64'(o_sat), 64'(e.sat));
`endif
        end
      end
      hold_vld = o_tvalid && !o_tready;
      hold_val = {o_tlast, o_tdata};
    end
  end

  logic [2*WI-1:0] dir_in [6] = '{
    {32'h00004000, 32'h00003FFF}, {32'hFFFFC000, 32'h00008000},
    {32'h7FFFFFFF, 32'h80000000}, {32'h3FFF0000, 32'h00000000},
    {32'hFFFF4000, 32'h3FFF8000}, {32'h3FFFC000, 32'hC0000000}};
  logic [2*WO-1:0] dir_out [6] = '{
    32'h00010000, 32'h00000001, 32'h7FFF8000, 32'h7FFE0000, 32'hFFFF7FFF, 32'h7FFF8000};
  logic dir_sat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    exp_t e;
    logic acc;
    int k, first_acc, last_acc;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tdata", 64'(o_tdata), 64'd0);
    chk("rst_tlast", 64'(o_tlast), 64'd0);
    chk("rst_occupied", 64'(occupied), 64'd0);
    chk("rst_tready", 64'(i_tready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rst", 64'(i_tready), 64'd1);

    // Literal rounding/clipping vectors
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      e.dat  = dir_out[i];
      e.last = (i % 2 == 1);
      e.sat  = dir_sat[i];
      send(dir_in[i], e.last, e);
    end
    drain();

    // Backpressure: 4 FIFO entries plus the stage-1 flop
    out_cyc_q.delete();
    rdy_mode = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      logic [2*WI-1:0] d;
      d = {rand_part(), rand_part()};
      step(1'b1, d, (k == 7), ref_beat(d, (k == 7)), acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd5);
    chk("bp_occupied", 64'(occupied), 64'd4);
    chk("bp_tready_low", 64'(i_tready), 64'd0);
    chk("bp_tvalid", 64'(o_tvalid), 64'd1);
    rdy_mode = 1;
    while (k < 8) begin
      send_rand(k == 7);
      k++;
    end
    drain();
    chk("bp_out_count", 64'(out_cyc_q.size()), 64'd8);

    // Throughput and latency
    out_cyc_q.delete();
    rdy_mode = 1;
    send_rand(1'b0);
    first_acc = last_acc_cyc;
    for (int i = 1; i < 100; i++) send_rand(i == 99);
    last_acc = last_acc_cyc;
    drain();
    chk("tp_in_span", 64'(last_acc - first_acc), 64'd99);
    chk("tp_out_count", 64'(out_cyc_q.size()), 64'd100);
    if (out_cyc_q.size() == 100) begin
      chk("tp_latency", 64'(out_cyc_q[0] - first_acc), 64'd2);
      chk("tp_out_span", 64'(out_cyc_q[99] - out_cyc_q[0]), 64'd99);
    end

    // Clear with the FIFO half full; the beat offered during clear is dropped
    out_cyc_q.delete();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    chk("clr_pre_occupied", 64'(occupied), 64'd2);
    clear = 1'b1;
    exp_q.delete();
    step(1'b1, {rand_part(), rand_part()}, 1'b1, '0, acc);
    clear = 1'b0;
    chk("clr_tvalid", 64'(o_tvalid), 64'd0);
    chk("clr_occupied", 64'(occupied), 64'd0);
    chk("clr_tdata", 64'(o_tdata), 64'd0);
    chk("clr_tlast", 64'(o_tlast), 64'd0);
    rdy_mode = 1;
    send_rand(1'b1);
    drain();
    chk("clr_out_count", 64'(out_cyc_q.size()), 64'd1);

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_rand($urandom_range(0, 7) == 0);
    end
    drain();

    // Asynchronous reset mid-stream with 3 beats held
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_rand(i == 2);
    chk("mr_pre_occupied", 64'(occupied), 64'd2);
    i_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_tvalid", 64'(o_tvalid), 64'd0);
    chk("mr_occupied", 64'(occupied), 64'd0);
    chk("mr_tready", 64'(i_tready), 64'd0);
    exp_q.delete();
    out_cyc_q.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_tready_after", 64'(i_tready), 64'd1);
    rdy_mode = 1;
    idle(10);
    chk("mr_no_stale", 64'(out_cyc_q.size()), 64'd0);
    send_rand(1'b1);
    drain();
    chk("mr_out_count", 64'(out_cyc_q.size()), 64'd1);

    $display("saturated beats observed: %0d", sat_beats);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
